instr_fetch_unit: RTL

Instruction fetch stage of the pipelined MIPS core and the initiating side of the instruction-memory read interface. It owns the program counter, drives `ReadAddress` into `Instruction_Mem`, captures the returned `Instruction`, and registers it into the IF/ID pipeline register. Stall, flush and branch/jump redirects come from the hazard unit and later stages.

---
 rtl/instr_fetch_unit.sv | 119 +++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: MIPS IF stage. Owns the PC, drives ReadAddress to the
// instruction memory and registers the returned word into IF/ID.
// Optional build macro FETCH_ALIGN_CHECK_EN: misaligned redirect targets are
// replaced by EXC_VECTOR and reported on misalign_exc.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h00400000,
  parameter logic [31:0] NOP_WORD   = 32'h00000000,
  parameter logic [31:0] EXC_VECTOR = 32'h80000180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] ReadAddress,
  input  logic [31:0] Instruction,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic        misalign_exc,
`endif
  output logic        if_id_valid
);

  typedef enum logic {S_RESET = 1'b0, S_RUN = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, pc_plus4;
  logic [31:0] tgt, tgt_eff;
  logic        redirect, run;
  logic [31:0] instr_d, pc4_d;
  logic        vld_d;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        misalign_d;
`endif

  assign ReadAddress = pc_q;
  assign pc_plus4    = pc_q + 32'd4;   // wraps silently at 2^32
  assign run         = (state_q == S_RUN);
  assign redirect    = branch_taken | jump;
  // branch is the older instruction, so it beats a jump
  assign tgt         = branch_taken ? branch_target : jump_target;

  // FSM state register; leaves RESET on the first edge after release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_RESET;
    else      state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (state_q == S_RESET) state_d = S_RUN;
  end

  // redirect target selection, with optional alignment trap
  always_comb begin
    tgt_eff = tgt;
`ifdef FETCH_ALIGN_CHECK_EN
    misalign_d = 1'b0;
    if (run && redirect && (tgt[1:0] != 2'b00)) begin
      tgt_eff    = EXC_VECTOR;
      misalign_d = 1'b1;
    end
`endif
  end

  // next PC: redirects override stall; RESET pins PC to the base
  always_comb begin
    pc_d = pc_q;
    if (!run)          pc_d = RESET_PC;
    else if (redirect) pc_d = tgt_eff;
    else if (stall)    pc_d = pc_q;
    else               pc_d = pc_plus4;
  end

  // next IF/ID: squash wrong-path / flushed words, hold on stall
  always_comb begin
    instr_d = if_id_instr;
    pc4_d   = if_id_pc_plus4;
    vld_d   = if_id_valid;
    if (!run || flush || redirect) begin
      instr_d = NOP_WORD;
      pc4_d   = 32'd0;
      vld_d   = 1'b0;
    end else if (!stall) begin
      instr_d = Instruction;
      pc4_d   = pc_plus4;
      vld_d   = 1'b1;
    end
  end

  // PC and IF/ID registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q           <= RESET_PC;
      if_id_instr    <= NOP_WORD;
      if_id_pc_plus4 <= 32'd0;
      if_id_valid    <= 1'b0;
    end else begin
      pc_q           <= pc_d;
      if_id_instr    <= instr_d;
      if_id_pc_plus4 <= pc4_d;
      if_id_valid    <= vld_d;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  // exception pulse lines up with EXC_VECTOR on ReadAddress
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) misalign_exc <= 1'b0;
    else      misalign_exc <= misalign_d;
  end
`endif

endmodule
